// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash responder: opcodes, FSM states, SR bit positions.
package spi_flash_pkg;

    localparam logic [7:0] OP_WRSR = 8'h01;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_RDCR = 8'h35;

    localparam int SR_WIP = 0;
    localparam int SR_WEL = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA_IN,
        ST_DATA_OUT,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin, with one-cycle rise/fall pulses.
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic ACLK,
    input  logic ARESETn,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;

    // Two synchronizing stages plus one history stage for edge detection
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) sync_q <= {3{RST_VAL}};
        else          sync_q <= {sync_q[1:0], async_in};
    end

    assign sync_out = sync_q[1];
    assign rise     = sync_q[1] & ~sync_q[2];
    assign fall     = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_flash_resp.sv
// Device-side single-bit SPI flash responder with internal byte array and SR/CR.
// Optional WIP busy emulation is enabled by defining SPI_FLASH_RESP_BUSY_EN.
//
// state       | meaning
// ST_IDLE     | CS low, waiting for the first SCK rise
// ST_CMD      | shifting in the opcode byte
// ST_ADDR     | shifting in the 24-bit address (READ / PP)
// ST_DATA_IN  | receiving WRSR or PP data bytes
// ST_DATA_OUT | driving RDSR / RDCR / READ bytes on IO1
// ST_IGNORE   | command done or rejected, IO1 released until CS high
module spi_flash_resp
    import spi_flash_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int BUSY_CYCLES = 64
) (
    input  logic ACLK,
    input  logic ARESETn,
    input  logic CS,
    input  logic CLOCK,
    input  logic IO0,
    inout  wire  IO1,
    input  logic IO2,
    input  logic IO3,
    input  logic VCC,
    input  logic GND,
    output logic flag_end_init
);

    localparam int AW = $clog2(DEPTH);
    // PP wraps inside a 256-byte page; smaller arrays simply wrap at DEPTH
    localparam logic [AW-1:0] PAGE_MASK = (AW > 8) ? AW'(255) : {AW{1'b1}};

    logic          cs_s, cs_rise, cs_fall_unused;
    logic          sck_s_unused, sck_rise, sck_fall;
    logic [1:0]    io0_q;
    logic          io0_s;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt, obit;
    logic [1:0]    byte_cnt;
    logic [7:0]    shift_in, shift_out, opcode;
    logic [15:0]   addr_sh;
    logic [AW-1:0] addr;
    logic          wel, wip, io1_oe, io1_q;
    logic [5:0]    sr_hi, sr_sh;
    logic [7:0]    cr, cr_sh;
    logic          wrsr_pend, pp_active, commit_q;
    logic [7:0]    byte_val, src_byte, sr_val;
    logic          byte_done, cmd_ok, mem_we, wrsr_commit, pp_end;
    logic [7:0]    mem [DEPTH];
    logic          unused_pins;

    spi_edge_sync #(.RST_VAL(1'b1)) u_cs_sync (
        .ACLK(ACLK), .ARESETn(ARESETn), .async_in(CS),
        .sync_out(cs_s), .rise(cs_rise), .fall(cs_fall_unused)
    );

    spi_edge_sync #(.RST_VAL(1'b0)) u_sck_sync (
        .ACLK(ACLK), .ARESETn(ARESETn), .async_in(CLOCK),
        .sync_out(sck_s_unused), .rise(sck_rise), .fall(sck_fall)
    );

    assign unused_pins = ^{IO2, IO3, VCC, GND, cs_fall_unused, sck_s_unused};
    assign io0_s       = io0_q[1];
    assign wrsr_commit = cs_rise & wrsr_pend & wel;
    assign pp_end      = cs_rise & pp_active;
    assign IO1         = io1_oe ? io1_q : 1'bz;

    // MOSI synchronizer, aligned with the SCK synchronizer depth
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) io0_q <= 2'b00;
        else          io0_q <= {io0_q[0], IO0};
    end

`ifdef SPI_FLASH_RESP_BUSY_EN
    localparam int BW = $clog2(BUSY_CYCLES + 1);
    logic [BW-1:0] busy_cnt;

    // WIP timer: loaded by a committed WRSR or the end of a PP
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)                  busy_cnt <= '0;
        else if (wrsr_commit || pp_end) busy_cnt <= BW'(BUSY_CYCLES);
        else if (busy_cnt != '0)       busy_cnt <= busy_cnt - 1'b1;
    end

    assign wip = (busy_cnt != '0);
`else
    logic unused_busy;
    assign unused_busy = ^BUSY_CYCLES;
    assign wip = 1'b0;
`endif

    // Next-state decode plus byte assembly and output byte selection
    always_comb begin
        state_d   = state_q;
        byte_val  = {shift_in[6:0], io0_s};
        byte_done = sck_rise && (bit_cnt == 3'd7);
        cmd_ok    = !(wip && (byte_val != OP_RDSR));
        mem_we    = 1'b0;
        sr_val    = {sr_hi, 2'b00};
        sr_val[SR_WEL] = wel;
        sr_val[SR_WIP] = wip;
        src_byte  = (opcode == OP_READ) ? mem[addr] :
                    (opcode == OP_RDSR) ? sr_val : cr;
        if (cs_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (sck_rise) state_d = ST_CMD;
                ST_CMD: begin
                    if (byte_done) begin
                        state_d = ST_IGNORE;
                        if (cmd_ok) begin
                            case (byte_val)
                                OP_RDSR, OP_RDCR: state_d = ST_DATA_OUT;
                                OP_WRSR:          state_d = ST_DATA_IN;
                                OP_READ:          state_d = ST_ADDR;
                                OP_PP:            state_d = wel ? ST_ADDR : ST_IGNORE;
                                default:          state_d = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (byte_done && byte_cnt == 2'd2)
                        state_d = (opcode == OP_READ) ? ST_DATA_OUT : ST_DATA_IN;
                end
                ST_DATA_IN: mem_we = byte_done && (opcode == OP_PP);
                default: ;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Shift registers, counters, status/config registers and CS-rise commits
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            bit_cnt   <= '0;
            obit      <= '0;
            byte_cnt  <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            opcode    <= '0;
            addr_sh   <= '0;
            addr      <= '0;
            wel       <= 1'b0;
            io1_oe    <= 1'b0;
            io1_q     <= 1'b0;
            sr_hi     <= '0;
            sr_sh     <= '0;
            cr        <= '0;
            cr_sh     <= '0;
            wrsr_pend <= 1'b0;
            pp_active <= 1'b0;
        end else if (cs_s) begin
            bit_cnt   <= '0;
            obit      <= '0;
            byte_cnt  <= '0;
            io1_oe    <= 1'b0;
            wrsr_pend <= 1'b0;
            pp_active <= 1'b0;
            if (wrsr_commit) begin
                sr_hi <= sr_sh;
                cr    <= cr_sh;
                wel   <= 1'b0;
            end
            if (pp_end) wel <= 1'b0;
        end else begin
            if (sck_rise) begin
                shift_in <= byte_val;
                bit_cnt  <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
                case (state_q)
                    ST_CMD: begin
                        opcode   <= byte_val;
                        byte_cnt <= '0;
                        if (cmd_ok) begin
                            if (byte_val == OP_WREN) wel <= 1'b1;
                            if (byte_val == OP_WRDI) wel <= 1'b0;
                            if (byte_val == OP_PP && wel) pp_active <= 1'b1;
                        end
                    end
                    ST_ADDR: begin
                        addr_sh  <= {addr_sh[7:0], byte_val};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd2) addr <= AW'({addr_sh, byte_val});
                    end
                    ST_DATA_IN: begin
                        if (opcode == OP_WRSR) begin
                            wrsr_pend <= 1'b1;
                            if (byte_cnt == 2'd0) sr_sh <= byte_val[7:2];
                            if (byte_cnt == 2'd1) cr_sh <= byte_val;
                            if (byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
                        end else begin
                            addr <= (addr & ~PAGE_MASK) | ((addr + AW'(1)) & PAGE_MASK);
                        end
                    end
                    default: ;
                endcase
            end
            if (sck_fall && state_q == ST_DATA_OUT) begin
                io1_oe <= 1'b1;
                obit   <= obit + 3'd1;
                if (obit == 3'd0) begin
                    io1_q     <= src_byte[7];
                    shift_out <= {src_byte[6:0], 1'b0};
                    if (opcode == OP_READ) addr <= addr + AW'(1);
                end else begin
                    io1_q     <= shift_out[7];
                    shift_out <= {shift_out[6:0], 1'b0};
                end
            end
        end
    end

    // Array write, one byte per completed PP data byte; contents survive reset
    always_ff @(posedge ACLK) begin
        if (mem_we) mem[addr] <= byte_val;
    end

    // Sticky init-done flag, one cycle after a commit that leaves CR[1] set
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            commit_q      <= 1'b0;
            flag_end_init <= 1'b0;
        end else begin
            commit_q <= wrsr_commit;
            if (commit_q && cr[1]) flag_end_init <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_flash_resp.sv
// Directed bench for spi_flash_resp: SPI mode-0 controller tasks and hand-computed expectations.
module tb_spi_flash_resp;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    logic CS = 1'b1;
    logic CLOCK = 1'b0;
    logic IO0 = 1'b0;
    logic IO2 = 1'b1;
    logic IO3 = 1'b1;
    logic VCC = 1'b1;
    logic GND = 1'b0;
    wire  io1;
    logic flag_end_init;

    int checks = 0;
    int failures = 0;
    logic [7:0] rx, rx2;

    spi_flash_resp #(.DEPTH(256), .BUSY_CYCLES(1500)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .CS(CS), .CLOCK(CLOCK), .IO0(IO0),
        .IO1(io1), .IO2(IO2), .IO3(IO3), .VCC(VCC), .GND(GND),
        .flag_end_init(flag_end_init)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i >= 8 - n; i--) begin
            IO0 = tx[i];
            #80;
            r[i] = io1;
            CLOCK = 1'b1;
            #80;
            CLOCK = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] r);
        spi_bits(tx, 8, r);
    endtask

    task automatic cs_lo();
        CS = 1'b0;
        #100;
    endtask

    task automatic cs_hi();
        #80;
        CS = 1'b1;
        #200;
    endtask

    task automatic settle();
`ifdef SPI_FLASH_RESP_BUSY_EN
        #16000;
`else
        #200;
`endif
    endtask

    task automatic cmd1(input logic [7:0] op);
        logic [7:0] d;
        cs_lo();
        xfer(op, d);
        cs_hi();
    endtask

    task automatic rd1(input logic [7:0] op, output logic [7:0] r);
        logic [7:0] d;
        cs_lo();
        xfer(op, d);
        xfer(8'h00, r);
        cs_hi();
    endtask

    task automatic send_addr(input logic [7:0] op, input logic [23:0] a);
        logic [7:0] d;
        xfer(op, d);
        xfer(a[23:16], d);
        xfer(a[15:8], d);
        xfer(a[7:0], d);
    endtask

    initial begin
        logic [7:0] d;
        #100;
        ARESETn = 1'b1;
        #100;

        check("reset_flag", {7'b0, flag_end_init}, 8'h00);
        check("reset_io1_oe", {7'b0, dut.io1_oe}, 8'h00);
        rd1(8'h05, rx);
        check("rdsr_reset", rx, 8'h00);
        check("flag_after_reset", {7'b0, flag_end_init}, 8'h00);

        cmd1(8'h06);
        rd1(8'h05, rx);
        check("rdsr_wren", rx, 8'h02);
        cmd1(8'h04);
        rd1(8'h05, rx);
        check("rdsr_wrdi", rx, 8'h00);

        cmd1(8'h06);
        cs_lo(); xfer(8'h05, d); xfer(8'h00, rx); xfer(8'h00, rx2); cs_hi();
        check("rdsr_repeat0", rx, 8'h02);
        check("rdsr_repeat1", rx2, 8'h02);
        cmd1(8'h04);

        cs_lo(); xfer(8'h01, d); xfer(8'h00, d); xfer(8'h02, d); cs_hi();
        settle();
        rd1(8'h35, rx);
        check("rdcr_no_wren", rx, 8'h00);
        check("flag_no_wren", {7'b0, flag_end_init}, 8'h00);

        cmd1(8'h06);
        cs_lo(); xfer(8'h01, d); xfer(8'h00, d); xfer(8'h02, d); cs_hi();
        check("flag_after_wrsr", {7'b0, flag_end_init}, 8'h01);
        settle();
        rd1(8'h35, rx);
        check("rdcr_after_wrsr", rx, 8'h02);
        rd1(8'h05, rx);
        check("rdsr_after_wrsr", rx, 8'h00);

        cmd1(8'h06);
        cs_lo(); send_addr(8'h02, 24'h0000FE);
        xfer(8'hA5, d); xfer(8'h5A, d); xfer(8'h3C, d); cs_hi();
        settle();
        rd1(8'h05, rx);
        check("rdsr_after_pp", rx, 8'h00);
        cs_lo(); send_addr(8'h03, 24'h0000FE); xfer(8'h00, rx); xfer(8'h00, rx2); cs_hi();
        check("read_fe", rx, 8'hA5);
        check("read_ff", rx2, 8'h5A);
        cs_lo(); send_addr(8'h03, 24'h000000); xfer(8'h00, rx); cs_hi();
        check("read_page_wrap", rx, 8'h3C);

        cmd1(8'h06);
        cs_lo(); send_addr(8'h02, 24'h000010); xfer(8'h77, d); xfer(8'h88, d); cs_hi();
        settle();
        cmd1(8'h06);
        cs_lo(); send_addr(8'h02, 24'h000011); spi_bits(8'hFF, 4, d); cs_hi();
        settle();
        cs_lo(); send_addr(8'h03, 24'h000010); xfer(8'h00, rx); xfer(8'h00, rx2); cs_hi();
        check("read_10", rx, 8'h77);
        check("partial_no_write", rx2, 8'h88);

        cs_lo(); xfer(8'h9F, d); xfer(8'h00, d);
        check("unknown_op_released", {7'b0, dut.io1_oe}, 8'h00);
        cs_hi();

`ifdef SPI_FLASH_RESP_BUSY_EN
        cmd1(8'h06);
        cs_lo(); send_addr(8'h02, 24'h000020); xfer(8'h11, d); cs_hi();
        rd1(8'h05, rx);
        check("rdsr_busy", rx, 8'h01);
        cs_lo(); send_addr(8'h03, 24'h000020); xfer(8'h00, d);
        check("read_busy_released", {7'b0, dut.io1_oe}, 8'h00);
        cs_hi();
        #15000;
        rd1(8'h05, rx);
        check("rdsr_busy_done", rx, 8'h00);
`endif

        cmd1(8'h06);
        cs_lo(); send_addr(8'h03, 24'h0000FE); xfer(8'h00, rx);
        check("read_before_reset", rx, 8'hA5);
        spi_bits(8'h00, 3, d);
        check("io1_driven_mid_read", {7'b0, dut.io1_oe}, 8'h01);
        ARESETn = 1'b0;
        #2;
        check("io1_released_on_reset", {7'b0, dut.io1_oe}, 8'h00);
        CS = 1'b1;
        #20;
        ARESETn = 1'b1;
        #200;
        rd1(8'h05, rx);
        check("rdsr_after_reset", rx, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
